i2s_tx_unpacker: RTL and testbench
==================================

# i2s_tx_unpacker

Upstream feeder for the I2S TX channel. Accepts 32-bit words from the uDMA TX stream, already in the `sck_i` domain, and splits each word into 1, 2 or 4 samples according to the configured sample size. Each sample goes out as a right-aligned 32-bit word on a valid/ready port. That port connects directly to the TX channel's FIFO data/valid/ready inputs. The block buffers one input word plus one output sample, and flags underruns when the channel pulls data that is not available.

## Interface
Parameters:
- none.

Ports (clock and reset first):
- `sck_i`  in  1  I2S bit clock; the only clock.
- `rstn_i`  in  1  reset, synchronous, active-low.
- `cfg_en_i`  in  1  enable; low flushes all state synchronously.
- `cfg_size_i`  in  2  sample size:
  - `00` = 8-bit
  - `01` = 16-bit
  - `10` = 32-bit
  - `11` = reserved, treated as 32-bit
- `cfg_signed_i`  in  1  sign-extend samples; port exists only with `I2S_TX_SIGN_EXT_EN`.
- `in_data_i`  in  32  packed word from the uDMA stream.
- `in_valid_i`  in  1  input word valid.
- `in_ready_o`  out  1  input word accepted when `in_valid_i & in_ready_o`.
- `out_data_o`  out  32  unpacked sample, right-aligned.
- `out_valid_o`  out  1  sample available.
- `out_ready_i`  in  1  sample consumed by the channel this cycle.
- `underrun_o`  out  1  one-cycle pulse on underrun.

## Operation
- **Holding stage.**
  - Registers: `r_word` [31:0], `r_full`, and lane index `r_idx` [1:0].
  - Lanes per word N = 4 / 2 / 1 for 8 / 16 / 32-bit samples.
  - Lane 0 is `in_data_i[w-1:0]` and is emitted first (little-endian lane order).
- **Output stage.** Registers: `r_out` [31:0] and `r_out_valid`.
- **Output load.** `load = r_full & (!r_out_valid | out_ready_i)`. On `load`:
  - `r_out` ← lane `r_idx` of `r_word`, zero-extended.
  - `r_out_valid` ← 1.
  - If `r_idx == N-1`: `r_idx` ← 0 and `r_full` ← 0. Otherwise `r_idx` ← `r_idx + 1`.
- **Output drain.** `out_ready_i & r_out_valid & !load` sets `r_out_valid` ← 0.
- **Input accept.** `in_ready_o = cfg_en_i & (!r_full | (load & r_idx == N-1))`.
  - On accept: `r_word` ← `in_data_i`, `r_full` ← 1, `r_idx` ← 0.
  - The last-lane load and the next word accept happen in the same cycle, so there is no bubble.
- **Underrun.** `underrun_o` is registered. It is 1 in the cycle after `cfg_en_i & out_ready_i & !r_out_valid`, otherwise 0.
- **Disable.** While `cfg_en_i` is low:
  - `r_full`, `r_out_valid`, `r_idx` and `underrun_o` are cleared every cycle.
  - `in_ready_o` = 0.
  - `r_word` and `r_out` hold their values.
- **Configuration changes.** `cfg_size_i` and `cfg_signed_i` change only while disabled. Behaviour with a mid-stream change is undefined but must not lock up; the block recovers on the next disable.
- **Reset.** While `rstn_i` is low at a `sck_i` edge, all registers are cleared:
  - `out_data_o` = 0, `out_valid_o` = 0, `underrun_o` = 0.
  - `in_ready_o` = 0, since it is gated by `cfg_en_i`.
  - Reset mid-word discards all pending lanes.

## Timing
- Latency: word accepted at edge t → first sample valid after edge t+1 (two register stages).
- Throughput:
  - Output: up to 1 sample per cycle.
  - Input: 1 word per N cycles under continuous `out_ready_i`.
- `out_data_o` and `out_valid_o` come straight from registers, with no combinational path from `out_ready_i`.
- `in_ready_o` depends combinationally on `out_ready_i`.
- Backpressure: `out_valid_o` and `out_data_o` stay stable while `out_ready_i` is low.

## Configuration
- `I2S_TX_SIGN_EXT_EN` defined:
  - Adds the `cfg_signed_i` port.
  - When `cfg_signed_i` = 1, 8- and 16-bit lanes are sign-extended into `r_out`. 32-bit lanes are unaffected.
- `I2S_TX_SIGN_EXT_EN` undefined: the port is absent and all lanes are zero-extended.

## Structure
- Package `i2s_pkg` holds:
  - sample-size encoding constants `I2S_SIZE_8`, `I2S_SIZE_16`, `I2S_SIZE_32`;
  - the lanes-per-word constant function.
- Sub-module `i2s_tx_lane_sel` (combinational) takes word, index, size and signed, and returns the extended 32-bit sample. It is reusable by an RX packer.

## Test plan
- **16-bit unpack.** Size `01`, feed `0xBEEF_1234`, `out_ready_i` held 1 → outputs `0x0000_1234` then `0x0000_BEEF`; `in_ready_o` high in the same cycle as the second load.
- **8-bit back-to-back.** Size `00`, words `0x44332211` and `0x88776655` offered continuously → 8 consecutive valid cycles, `0x11` … `0x88`, with no gap.
- **Backpressure.** Size `10`, `out_ready_i` low for 5 cycles → `out_data_o` holds the first word, `in_ready_o` = 1 exactly once more, then 0 until drained.
- **Underrun.** Enabled, no input, `out_ready_i` pulsed at cycle 10 → `underrun_o` = 1 at cycle 11 only; no pulse while `cfg_en_i` = 0.
- **Flush.** Deassert `cfg_en_i` mid-word with 2 lanes pending → `out_valid_o` = 0 next cycle; after re-enable, the first output comes from the next new word.
- **Sign extension (with `I2S_TX_SIGN_EXT_EN`).** Size `01`, signed, word `0x7FFF_8000` → `0xFFFF_8000` then `0x0000_7FFF`.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared definitions for the I2S TX unpacker and the lane selector.
//   I2S_SIZE_*      : cfg_size_i encodings (2'b11 is reserved and handled as 32-bit)
//   lanes_per_word  : number of samples carried by one 32-bit word for a given size
package i2s_pkg;

  localparam logic [1:0] I2S_SIZE_8  = 2'b00;
  localparam logic [1:0] I2S_SIZE_16 = 2'b01;
  localparam logic [1:0] I2S_SIZE_32 = 2'b10;

  function automatic logic [2:0] lanes_per_word(input logic [1:0] size);
    case (size)
      I2S_SIZE_8:  return 3'd4;
      I2S_SIZE_16: return 3'd2;
      default:     return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/i2s_tx_lane_sel.sv
// i2s_tx_lane_sel: combinational lane extractor.
// Picks lane idx_i out of word_i for the given sample size and returns it
// right-aligned in 32 bits, sign-extended when sign_i is set (8/16-bit only).
// Ports:
//   word_i   [31:0] packed word
//   idx_i    [1:0]  lane index (lane 0 = least significant)
//   size_i   [1:0]  sample size encoding (i2s_pkg::I2S_SIZE_*)
//   sign_i          sign-extend narrow lanes
//   sample_o [31:0] extended sample
module i2s_tx_lane_sel
  import i2s_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  idx_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] sample_o
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  assign lane8  = word_i[{idx_i, 3'b000} +: 8];
  // Only idx_i[0] matters for 16-bit lanes; a stale upper bit after a
  // mid-stream size change just aliases onto a valid lane.
  assign lane16 = word_i[{idx_i[0], 4'b0000} +: 16];

  always_comb begin
    sample_o = word_i;
    case (size_i)
      I2S_SIZE_8:  sample_o = {{24{sign_i & lane8[7]}}, lane8};
      I2S_SIZE_16: sample_o = {{16{sign_i & lane16[15]}}, lane16};
      default:     sample_o = word_i;
    endcase
  end

endmodule

// File: rtl/i2s_tx_unpacker.sv
// i2s_tx_unpacker: splits 32-bit uDMA words into 1/2/4 right-aligned samples
// for the I2S TX channel FIFO. One word is held plus one output sample.
// Optional feature macro: I2S_TX_SIGN_EXT_EN (adds cfg_signed_i, enables
// sign extension of 8/16-bit samples). Default build zero-extends.
// Ports:
//   sck_i, rstn_i            bit clock, synchronous active-low reset
//   cfg_en_i                 enable; low flushes pending data
//   cfg_size_i [1:0]         00=8b, 01=16b, 10/11=32b
//   cfg_signed_i             sign-extend (only with I2S_TX_SIGN_EXT_EN)
//   in_data_i/valid/ready    packed word input
//   out_data_o/valid/ready   sample output (registered data/valid)
//   underrun_o               one-cycle pulse after a pull with no data
module i2s_tx_unpacker
  import i2s_pkg::*;
(
  input  logic        sck_i,
  input  logic        rstn_i,
  input  logic        cfg_en_i,
  input  logic [1:0]  cfg_size_i,
`ifdef I2S_TX_SIGN_EXT_EN
  input  logic        cfg_signed_i,
`endif
  input  logic [31:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        underrun_o
);

  logic [31:0] word_q, word_d;
  logic        full_q, full_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic        underrun_q, underrun_d;

  logic [1:0]  last_idx;
  logic        last;
  logic        load;
  logic        accept;
  logic        sign;
  logic [31:0] lane;

`ifdef I2S_TX_SIGN_EXT_EN
  assign sign = cfg_signed_i;
`else
  assign sign = 1'b0;
`endif

  assign last_idx = 2'(lanes_per_word(cfg_size_i) - 3'd1);
  assign last     = (idx_q == last_idx);
  assign load     = full_q & (~out_valid_q | out_ready_i);
  // Last-lane load frees the holding register in the same cycle, so the
  // next word can be taken without a bubble.
  assign in_ready_o = cfg_en_i & (~full_q | (load & last));
  assign accept     = in_valid_i & in_ready_o;

  i2s_tx_lane_sel u_lane_sel (
    .word_i   (word_q),
    .idx_i    (idx_q),
    .size_i   (cfg_size_i),
    .sign_i   (sign),
    .sample_o (lane)
  );

  always_comb begin
    word_d      = word_q;
    full_d      = full_q;
    idx_d       = idx_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    underrun_d  = cfg_en_i & out_ready_i & ~out_valid_q;

    if (!cfg_en_i) begin
      full_d      = 1'b0;
      out_valid_d = 1'b0;
      idx_d       = 2'd0;
      underrun_d  = 1'b0;
    end else begin
      if (load) begin
        out_d       = lane;
        out_valid_d = 1'b1;
        if (last) begin
          idx_d  = 2'd0;
          full_d = 1'b0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end else if (out_ready_i && out_valid_q) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        word_d = in_data_i;
        full_d = 1'b1;
        idx_d  = 2'd0;
      end
    end
  end

  always_ff @(posedge sck_i) begin
    if (!rstn_i) begin
      word_q      <= '0;
      full_q      <= 1'b0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      word_q      <= word_d;
      full_q      <= full_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign out_data_o  = out_q;
  assign out_valid_o = out_valid_q;
  assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_i2s_tx_unpacker.sv
// tb_i2s_tx_unpacker: directed self-checking bench for i2s_tx_unpacker.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_i2s_tx_unpacker;

  logic        sck_i = 1'b0;
  logic        rstn_i;
  logic        cfg_en_i;
  logic [1:0]  cfg_size_i;
`ifdef I2S_TX_SIGN_EXT_EN
  logic        cfg_signed_i;
`endif
  logic [31:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        underrun_o;

  int errors = 0;
  int checks = 0;

  always #5 sck_i = ~sck_i;

  i2s_tx_unpacker dut (
    .sck_i        (sck_i),
    .rstn_i       (rstn_i),
    .cfg_en_i     (cfg_en_i),
    .cfg_size_i   (cfg_size_i),
`ifdef I2S_TX_SIGN_EXT_EN
    .cfg_signed_i (cfg_signed_i),
`endif
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .underrun_o   (underrun_o)
  );

  task automatic tick();
    @(posedge sck_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp8 [8] = '{32'h11, 32'h22, 32'h33, 32'h44,
                            32'h55, 32'h66, 32'h77, 32'h88};

  initial begin
    rstn_i      = 1'b0;
    cfg_en_i    = 1'b0;
    cfg_size_i  = 2'b00;
`ifdef I2S_TX_SIGN_EXT_EN
    cfg_signed_i = 1'b0;
`endif
    in_data_i   = '0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_data", out_data_o, 32'h0);
    chk("rst_valid", {31'b0, out_valid_o}, 32'h0);
    chk("rst_underrun", {31'b0, underrun_o}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready_o}, 32'h0);
    rstn_i = 1'b1;

    // 16-bit unpack, out_ready held high
    cfg_size_i  = 2'b01;
    cfg_en_i    = 1'b1;
    out_ready_i = 1'b1;
    in_data_i   = 32'hBEEF_1234;
    in_valid_i  = 1'b1;
    #1;
    chk("u16_in_ready_empty", {31'b0, in_ready_o}, 32'h1);
    tick();
    in_valid_i = 1'b0;
    chk("u16_valid_after_accept", {31'b0, out_valid_o}, 32'h0);
    chk("u16_underrun_a", {31'b0, underrun_o}, 32'h1);
    tick();
    chk("u16_lane0", out_data_o, 32'h0000_1234);
    chk("u16_lane0_valid", {31'b0, out_valid_o}, 32'h1);
    chk("u16_in_ready_last_load", {31'b0, in_ready_o}, 32'h1);
    tick();
    chk("u16_lane1", out_data_o, 32'h0000_BEEF);
    chk("u16_lane1_valid", {31'b0, out_valid_o}, 32'h1);
    chk("u16_underrun_c", {31'b0, underrun_o}, 32'h0);
    tick();
    chk("u16_drained", {31'b0, out_valid_o}, 32'h0);
    out_ready_i = 1'b0;

    // 8-bit back-to-back words
    cfg_en_i = 1'b0;
    tick();
    cfg_size_i  = 2'b00;
    cfg_en_i    = 1'b1;
    out_ready_i = 1'b1;
    in_data_i   = 32'h4433_2211;
    in_valid_i  = 1'b1;
    tick();
    in_data_i = 32'h8877_6655;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("u8_valid_%0d", i), {31'b0, out_valid_o}, 32'h1);
      chk($sformatf("u8_data_%0d", i), out_data_o, exp8[i]);
      if (i == 3) in_valid_i = 1'b0;
    end
    tick();
    chk("u8_drained", {31'b0, out_valid_o}, 32'h0);
    out_ready_i = 1'b0;

    // 32-bit backpressure
    cfg_en_i = 1'b0;
    tick();
    cfg_size_i = 2'b10;
    cfg_en_i   = 1'b1;
    in_data_i  = 32'hA000_0001;
    in_valid_i = 1'b1;
    tick();
    in_data_i = 32'hB000_0002;
    chk("bp_in_ready_once_more", {31'b0, in_ready_o}, 32'h1);
    tick();
    in_data_i = 32'hC000_0003;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_data_%0d", i), out_data_o, 32'hA000_0001);
      chk($sformatf("bp_hold_valid_%0d", i), {31'b0, out_valid_o}, 32'h1);
      chk($sformatf("bp_hold_in_ready_%0d", i), {31'b0, in_ready_o}, 32'h0);
      tick();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    #1;
    chk("bp_in_ready_release", {31'b0, in_ready_o}, 32'h1);
    tick();
    chk("bp_second_word", out_data_o, 32'hB000_0002);
    tick();
    chk("bp_drained", {31'b0, out_valid_o}, 32'h0);
    out_ready_i = 1'b0;

    // Underrun pulse
    tick(); tick();
    chk("ur_quiet", {31'b0, underrun_o}, 32'h0);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("ur_pulse", {31'b0, underrun_o}, 32'h1);
    tick();
    chk("ur_pulse_end", {31'b0, underrun_o}, 32'h0);
    cfg_en_i    = 1'b0;
    out_ready_i = 1'b1;
    tick(); tick();
    chk("ur_disabled", {31'b0, underrun_o}, 32'h0);
    out_ready_i = 1'b0;

    // Flush with two lanes pending
    cfg_size_i = 2'b00;
    cfg_en_i   = 1'b1;
    in_data_i  = 32'h4433_2211;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    chk("fl_lane0", out_data_o, 32'h11);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("fl_lane1", out_data_o, 32'h22);
    cfg_en_i = 1'b0;
    tick();
    chk("fl_valid_cleared", {31'b0, out_valid_o}, 32'h0);
    chk("fl_in_ready_off", {31'b0, in_ready_o}, 32'h0);
    chk("fl_data_hold", out_data_o, 32'h22);
    cfg_en_i    = 1'b1;
    in_data_i   = 32'hDDCC_BBAA;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("fl_no_stale", {31'b0, out_valid_o}, 32'h0);
    tick();
    chk("fl_new_word", out_data_o, 32'hAA);
    out_ready_i = 1'b0;

    // Reset mid-word discards pending lanes
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    chk("mr_data", out_data_o, 32'h0);
    chk("mr_valid", {31'b0, out_valid_o}, 32'h0);
    tick();
    chk("mr_no_resume", {31'b0, out_valid_o}, 32'h0);

`ifdef I2S_TX_SIGN_EXT_EN
    cfg_en_i = 1'b0;
    tick();
    cfg_size_i   = 2'b01;
    cfg_signed_i = 1'b1;
    cfg_en_i     = 1'b1;
    out_ready_i  = 1'b1;
    in_data_i    = 32'h7FFF_8000;
    in_valid_i   = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    chk("se_lane0", out_data_o, 32'hFFFF_8000);
    tick();
    chk("se_lane1", out_data_o, 32'h0000_7FFF);
    out_ready_i  = 1'b0;
    cfg_en_i     = 1'b0;
    cfg_signed_i = 1'b0;
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
